// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, coordinate type and window helper for the VGA raster generator.
// Default values describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int COORD_W        = 10;

    localparam int H_VISIBLE_DEF  = 640;
    localparam int H_FRONT_DEF    = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int V_VISIBLE_DEF  = 480;
    localparam int V_FRONT_DEF    = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam int PIPE_DELAY_DEF = 2;

    localparam int H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    typedef logic [COORD_W-1:0] coord_t;

    // Compared in int so a window ending exactly at 1024 does not wrap.
    function automatic logic in_window(coord_t c, int lo, int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster coordinate and sync stream from the timing generator to the drawers and colour mux.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   blank_d;
    logic   hs_d;
    logic   vs_d;
    logic   line_start;
    logic   frame_start;

    modport master (
        output DrawX, DrawY, blank, hs, vs, blank_d, hs_d, vs_d, line_start, frame_start
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, blank_d, hs_d, vs_d, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register; a synchronous reset loads every stage with RESET_VAL at once.
// DEPTH of 0 passes the input straight through.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int NSTAGE = (DEPTH == 0) ? 1 : DEPTH;

    logic [WIDTH-1:0] stage [NSTAGE];

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < NSTAGE; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = (DEPTH == 0) ? din : stage[NSTAGE-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters, registered blank/sync derived from next-state counts,
// and a delayed sync copy that lines up with the drawers' registered colour output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic          vga_clk,
    input  logic          reset,
    vga_timing_if.master  vid
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: line or frame total exceeds the 10-bit counter range");
    end

    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
    end

    coord_t h_cnt;
    coord_t v_cnt;
    coord_t h_nxt;
    coord_t v_nxt;
    logic   h_wrap;
    logic   blank_r;
    logic   hs_r;
    logic   vs_r;
    logic   line_start_r;
    logic   frame_start_r;
    logic [2:0] sync_d;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + coord_t'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
        end
    end

    // Flags are computed from the next counts so they describe the same cycle as DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            blank_r       <= 1'b1;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            blank_r       <= in_window(h_nxt, 0, H_VISIBLE) && in_window(v_nxt, 0, V_VISIBLE);
            hs_r          <= !in_window(h_nxt, HS_START, HS_END);
            vs_r          <= !in_window(v_nxt, VS_START, VS_END);
            line_start_r  <= (h_nxt == '0);
            frame_start_r <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (3'b011)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     ({blank_r, hs_r, vs_r}),
        .dout    (sync_d)
    );

    assign vid.DrawX       = h_cnt;
    assign vid.DrawY       = v_cnt;
    assign vid.blank       = blank_r;
    assign vid.hs          = hs_r;
    assign vid.vs          = vs_r;
    assign vid.line_start  = line_start_r;
    assign vid.frame_start = frame_start_r;
    assign vid.blank_d     = sync_d[2];
    assign vid.hs_d        = sync_d[1];
    assign vid.vs_d        = sync_d[0];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from `vga_clk` (25 MHz pixel clock). It produces the `DrawX`/`DrawY`/`blank` coordinate stream consumed by every sprite/asset drawer, which all use a ROM-read plus output-register pipeline. It also produces active-low `hs`/`vs`, plus copies delayed by a fixed number of cycles so sync stays aligned with the drawers' colour outputs. It sits at the top of the video path, upstream of all drawers and the colour mux.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FRONT`, default 16: horizontal front porch
- `H_SYNC`, default 96: horizontal sync width
- `H_BACK`, default 48: horizontal back porch (line total 800)
- `V_VISIBLE`, default 480: visible lines
- `V_FRONT`, default 10: vertical front porch
- `V_SYNC`, default 2: vertical sync width
- `V_BACK`, default 33: vertical back porch (frame total 525)
- `PIPE_DELAY`, default 2: cycles of delay on `blank_d`/`hs_d`/`vs_d`; legal range 0..7
- `vga_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `DrawX`  out  10  horizontal counter, 0..799
- `DrawY`  out  10  vertical counter, 0..524
- `blank`  out  1  1 = visible pixel (DrawX<640 && DrawY<480), 0 = blanking
- `hs`  out  1  horizontal sync, active low, aligned with DrawX
- `vs`  out  1  vertical sync, active low, aligned with DrawY
- `blank_d`, `hs_d`, `vs_d`  out  1 each  `blank`/`hs`/`vs` delayed by PIPE_DELAY cycles
- `line_start`  out  1  one-cycle pulse when DrawX wraps to 0
- `frame_start`  out  1  one-cycle pulse when DrawX and DrawY both wrap to 0

## Operation
- Two counters, H and V, exposed directly as `DrawX`/`DrawY`.
- H increments every cycle. At H_TOTAL-1 (799) H wraps to 0 and V advances.
- V wraps from V_TOTAL-1 (524) to 0 when H wraps.
- `blank`, `hs` and `vs` are registered. Each is computed from the next-state counter values, so its value always describes the current `DrawX`/`DrawY` and never lags by a cycle.
- `hs` = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- `vs` = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- `line_start` = 1 in each cycle where DrawX=0, except the first line after reset. `frame_start` = 1 when DrawX=0 and DrawY=0, except the first frame after reset.
- The delayed outputs come from a shift register of depth PIPE_DELAY.
  - PIPE_DELAY=0: each delayed output equals its undelayed source.
  - During reset every stage loads the inactive values (blank 0, hs 1, vs 1).
- Reset values: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, blank_d=0, hs_d=1, vs_d=1, line_start=0, frame_start=0.
- Reset asserted mid-frame: on the next edge, all outputs take their reset values regardless of counter state.
- Counter widths are fixed at 10 bits. Parameter sets with a total above 1024 are illegal; an elaboration-time assertion enforces this.

## Timing
- No latency from clock edge to counter: one pixel per `vga_clk`. A line is 800 cycles; a frame is 420000 cycles.
- First cycle after reset is released: DrawX=0, DrawY=0. DrawX becomes 1 after one more edge.
- Line wrap: the cycle after DrawX=799 shows DrawX=0, DrawY+1, line_start=1.
- Frame wrap: the cycle after (799,524) shows (0,0), line_start=1, frame_start=1.
- `hs` falls in the cycle where DrawX=656 and rises in the cycle where DrawX=752.
- `vs` falls across the whole line where DrawY=490, starting at DrawX=0, and rises at DrawY=492, DrawX=0.
- `blank` falls at DrawX=640 on visible lines, and stays 0 for all of lines 480..524.
- `hs_d`, `vs_d` and `blank_d` transition exactly PIPE_DELAY edges after the corresponding undelayed signal.
- With the default PIPE_DELAY=2, they line up with a drawer's registered colour output, whose address is computed from the same DrawX/DrawY.

## Structure
- Package `vga_timing_pkg` holds:
  - default timing constants;
  - derived H_TOTAL/V_TOTAL and sync start/end localparams;
  - a typedef for the 10-bit coordinate (`coord_t`).
- Sub-module `sync_delay_line`:
  - parameterised width and depth, synchronous reset to a parameter value;
  - instantiated once, 3 bits wide, for blank/hs/vs.

## Test plan
- Reset held 5 cycles, then released → DrawX=0, DrawY=0, blank=1, hs=vs=hs_d=vs_d=1, blank_d=0, no pulses. After 10 edges DrawX=10.
- Run 800 cycles → DrawX wraps 799→0 with DrawY 0→1. line_start is high for exactly one cycle, and frame_start stays 0.
- Scan one line → hs is low for exactly 96 cycles, DrawX 656..751. blank=1 for DrawX 0..639 only. hs_d falls exactly 2 cycles after hs.
- Run a full frame of 420000 cycles → vs is low for exactly 1600 cycles (DrawY 490..491). frame_start pulses once, at (0,0). blank=0 for every cycle with DrawY≥480.
- Assert reset at DrawX=300, DrawY=200 → the next cycle shows all reset values. The delay line is flushed to its inactive values, and counting restarts from (0,0).
- Instantiate with PIPE_DELAY=0 → hs_d≡hs, vs_d≡vs, blank_d≡blank on every cycle after reset.
